// File: rtl/lmc_control.sv
// Fetch/decode/execute sequencer for the R3 accumulator datapath.
// Moore outputs decoded from state and IR; each instruction takes three cycles.
module lmc_control #(
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned DATA_WIDTH = 4
) (
   input  logic                  timer555,
   input  logic                  reset_n,
   input  logic                  run,
   input  logic [DATA_WIDTH-1:0] RAM_out,
   input  logic [ADDR_WIDTH-1:0] counter,
   output logic                  Addr_sel,
   output logic [ADDR_WIDTH-1:0] addr_operand,
   output logic                  Counter_inc,
   output logic                  Counter_load,
   output logic                  Acc_button,
   output logic                  MUX_switch,
   output logic                  RAM_button,
   output logic [DATA_WIDTH-1:0] ir,
   output logic                  busy,
   output logic                  halted
);

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_e;
   typedef enum logic [1:0] {OP_LDA = 2'b00, OP_ADD = 2'b01, OP_STA = 2'b10, OP_BRA = 2'b11} op_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] ir_q, ir_d;
   op_e                   opcode;
   logic                  self_jump;

   assign opcode       = op_e'(ir_q[DATA_WIDTH-1 -: 2]);
   assign self_jump    = (ir_q[ADDR_WIDTH-1:0] == counter);
   assign addr_operand = ir_q[ADDR_WIDTH-1:0];
   assign ir           = ir_q;

   always_ff @(posedge timer555 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         IDLE:    if (run) state_d = FETCH;
         FETCH: begin
            ir_d    = RAM_out;
            state_d = DECODE;
         end
         DECODE:  state_d = EXEC;
         EXEC:    state_d = (opcode == OP_BRA && self_jump) ? HALT : FETCH;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // Strobes come only from the registered state, so async reset clears them at once.
   always_comb begin
      Addr_sel     = 1'b0;
      Counter_inc  = 1'b0;
      Counter_load = 1'b0;
      Acc_button   = 1'b0;
      MUX_switch   = 1'b0;
      RAM_button   = 1'b0;
      busy         = 1'b0;
      halted       = 1'b0;
      case (state_q)
         FETCH:  busy = 1'b1;
         DECODE: begin
            busy     = 1'b1;
            Addr_sel = 1'b1;
         end
         EXEC: begin
            busy     = 1'b1;
            Addr_sel = 1'b1;
            case (opcode)
               OP_LDA: begin
                  Acc_button  = 1'b1;
                  Counter_inc = 1'b1;
               end
               OP_ADD: begin
                  Acc_button  = 1'b1;
                  MUX_switch  = 1'b1;
                  Counter_inc = 1'b1;
               end
               OP_STA: begin
                  RAM_button  = 1'b1;
                  Counter_inc = 1'b1;
               end
               OP_BRA:  Counter_load = !self_jump;
               default: ;
            endcase
         end
         HALT:    halted = 1'b1;
         default: ;
      endcase
   end

endmodule
